// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin arbiter that shares one UART transmitter between
//            NUM_REQ byte producers. One byte is accepted per valid/ready
//            handshake. The transmitter's start input is pulsed with the byte
//            held stable. Baud ticks are counted to find the end of the frame,
//            and an optional idle gap is inserted before the next grant.
// Ports    : clk        - system clock
//            reset      - synchronous, active-low reset
//            req_valid  - per-requester byte valid          [NUM_REQ]
//            req_data   - packed bytes, requester i at [8i+7:8i]
//            req_ready  - one-hot accept pulse               [NUM_REQ]
//            baud_tick  - one-clk tick from the baud generator
//            tx_start   - one-clk start pulse to uart_tx
//            tx_data    - byte to uart_tx, stable until the next accept
//            busy       - high whenever the scheduler is not idle
//            grant_id   - index of the last or current granted requester
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = 10,
    parameter int GAP_TICKS   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       baud_tick,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int SUM_W   = PTR_W + 1;
    localparam int CNT_MAX = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Count values reached just before the terminating tick.
    localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [PTR_W-1:0] c_ptr_top    = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FRAME  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [7:0]         r_tx_data;
    logic [PTR_W-1:0]   r_grant;

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [SUM_W-1:0]   w_sum;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan offsets from the highest down so the last hit
    // written is the one closest to the pointer (searching upward, wrapping).
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            if (req_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_accept) begin
            w_ptr_next = (w_sel == c_ptr_top) ? '0 : w_sel + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The counter is cleared in LAUNCH so that a tick
    // coinciding with the start pulse is not part of the frame.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_next   = '0;
                w_state_next = S_FRAME;
            end
            S_FRAME: begin
                if (baud_tick) begin
                    if (r_cnt == c_frame_last) begin
                        w_cnt_next   = '0;
                        w_state_next = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (baud_tick) begin
                    if (r_cnt == c_gap_last) begin
                        w_cnt_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_tx_data <= 8'h00;
            r_grant   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            if (w_accept) begin
                r_tx_data <= req_data[{w_sel, 3'b000} +: 8];
                r_grant   <= w_sel;
            end
        end
    end

    assign req_ready = w_ready;
    assign tx_start  = (r_state == S_LAUNCH);
    assign tx_data   = r_tx_data;
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Self-checking bench for uart_tx_scheduler. One instance uses no
//            inter-frame gap, a second instance uses a two-tick gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    logic        clk;
    logic        reset;

    logic [3:0]  valid1;
    logic [31:0] data1;
    logic        tick1;
    logic [3:0]  ready1;
    logic        start1;
    logic [7:0]  txd1;
    logic        busy1;
    logic [1:0]  gid1;

    logic [3:0]  valid2;
    logic [31:0] data2;
    logic        tick2;
    logic [3:0]  ready2;
    logic        start2;
    logic [7:0]  txd2;
    logic        busy2;
    logic [1:0]  gid2;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(10), .GAP_TICKS(0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (valid1),
        .req_data  (data1),
        .req_ready (ready1),
        .baud_tick (tick1),
        .tx_start  (start1),
        .tx_data   (txd1),
        .busy      (busy1),
        .grant_id  (gid1)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .FRAME_TICKS(10), .GAP_TICKS(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (valid2),
        .req_data  (data2),
        .req_ready (ready2),
        .baud_tick (tick2),
        .tx_start  (start2),
        .tx_data   (txd2),
        .busy      (busy2),
        .grant_id  (gid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        tick;
        logic [3:0]  ready;
        logic        start;
        logic        busy;
        logic [7:0]  txd;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete frame on dut1: accept, launch, then 10 ticks spread over
    // 20 cycles (tick on odd cycles), so the next call starts in IDLE.
    task automatic run_frame(input logic [3:0] v, input int g, input logic [7:0] b);
        int quiet;
        @(negedge clk);
        valid1 = v;
        tick1  = 1'b0;
        #1;
        chk("rr_ready", 32'(ready1), 32'(1 << g));
        @(negedge clk);
        tick1 = 1'b0;
        #1;
        chk("rr_start", 32'(start1), 32'd1);
        chk("rr_data",  32'(txd1),   32'(b));
        chk("rr_grant", 32'(gid1),   32'(g));
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tick1 = (k % 2 == 1);
            #1;
            if (start1 !== 1'b0 || ready1 !== 4'h0 || busy1 !== 1'b1) quiet++;
        end
        chk("rr_frame_quiet", 32'(quiet), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int gq;

        // ---------------- vector table: reset + single byte ----------------
        vecs[0] = '{1'b0, 4'h0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[1] = '{1'b1, 4'h1, 32'h0000_00A5, 1'b0, 4'h1, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[2] = '{1'b1, 4'h0, 32'h0,        1'b1, 4'h0, 1'b1, 1'b1, 8'hA5, 2'd0};
        for (int k = 3; k <= 12; k++) begin
            vecs[k] = '{1'b1, 4'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b1, 8'hA5, 2'd0};
        end
        vecs[13] = '{1'b1, 4'h0, 32'h0,       1'b0, 4'h0, 1'b0, 1'b0, 8'hA5, 2'd0};

        reset  = 1'b0;
        valid1 = '0; data1 = '0; tick1 = 1'b0;
        valid2 = '0; data2 = '0; tick2 = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            reset  = vecs[i].rst_n;
            valid1 = vecs[i].valid;
            data1  = vecs[i].data;
            tick1  = vecs[i].tick;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(ready1), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_start", i), 32'(start1), 32'(vecs[i].start));
            chk($sformatf("vec%0d_busy",  i), 32'(busy1),  32'(vecs[i].busy));
            chk($sformatf("vec%0d_data",  i), 32'(txd1),   32'(vecs[i].txd));
            chk($sformatf("vec%0d_grant", i), 32'(gid1),   32'(vecs[i].gid));
        end

        // ---------------- round-robin from a fresh pointer ----------------
        @(negedge clk);
        reset = 1'b0; valid1 = 4'h0; tick1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        data1 = 32'h1312_1110;
        run_frame(4'hF, 0, 8'h10);
        run_frame(4'hF, 1, 8'h11);
        run_frame(4'hF, 2, 8'h12);
        run_frame(4'hF, 3, 8'h13);
        run_frame(4'hF, 0, 8'h10);

        // ---------------- wrap and skip ----------------
        run_frame(4'h4, 2, 8'h12);
        run_frame(4'h5, 0, 8'h10);
        run_frame(4'h5, 2, 8'h12);

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        valid1 = 4'h2; tick1 = 1'b0;
        #1;
        chk("mid_ready", 32'(ready1), 32'h2);
        @(negedge clk);
        valid1 = 4'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tick1 = (k != 0);
        end
        @(negedge clk);
        reset = 1'b0; tick1 = 1'b0;
        #1;
        chk("mid_busy_before", 32'(busy1), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready1), 32'h0);
        chk("rst_start", 32'(start1), 32'h0);
        chk("rst_data",  32'(txd1),   32'h0);
        chk("rst_busy",  32'(busy1),  32'h0);
        chk("rst_grant", 32'(gid1),   32'h0);
        @(negedge clk);
        reset = 1'b1; valid1 = 4'hF;
        #1;
        chk("post_rst_ready", 32'(ready1), 32'h1);
        @(negedge clk);
        valid1 = 4'h0;
        #1;
        chk("post_rst_start", 32'(start1), 32'h1);
        chk("post_rst_data",  32'(txd1),   32'h10);
        chk("post_rst_grant", 32'(gid1),   32'h0);

        // ---------------- inter-frame gap (dut2) ----------------
        @(negedge clk);
        valid2 = 4'h3; data2 = 32'h0000_BBAA; tick2 = 1'b0;
        #1;
        chk("gap_ready0", 32'(ready2), 32'h1);
        @(negedge clk);
        tick2 = 1'b1;
        #1;
        chk("gap_start", 32'(start2), 32'h1);
        chk("gap_data",  32'(txd2),   32'hAA);
        gq = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            tick2 = 1'b1;
            #1;
            if (ready2 !== 4'h0) gq++;
            if (n == 11) chk("gap_busy_in_gap", 32'(busy2), 32'h1);
        end
        chk("gap_held_off", 32'(gq), 32'd0);
        @(negedge clk);
        tick2 = 1'b0;
        #1;
        chk("gap_ready1", 32'(ready2), 32'h2);
        chk("gap_idle",   32'(busy2),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter (baud tick generator plus uart_tx) between NUM_REQ byte producers.
- Accepts one byte per valid/ready handshake and pulses the transmitter's start input with the byte held stable.
- Counts baud ticks to find the end of the frame, then enforces an optional inter-frame gap before granting again.
- Sits between the producers and uart_tx_top's start/data inputs; it consumes baud_wire as its tick input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FRAME_TICKS, 10, baud ticks per frame: 1 start + 8 data + 1 stop.
- GAP_TICKS, 0, extra idle baud ticks after each frame (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte-valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- baud_tick  in  1  one-clk tick from the baud generator.
- tx_start  out  1  one-clk start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; held stable from the start pulse to the end of the frame.
- busy  out  1  high whenever the block is not in IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the last or current granted requester.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - req_ready=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0.
  - Round-robin pointer=0; tick counters=0.
  - Applies mid-frame: the frame is abandoned with no completion and no accept pulse. The transmitter's own reset is outside this block.
- States: IDLE, LAUNCH, FRAME, GAP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise select the first set bit searching from the pointer upward, wrapping modulo NUM_REQ. Call it g.
  - In the same cycle (combinational from registered state and req_valid): req_ready[g]=1.
  - On the clk edge: capture req_data[g] into tx_data, set grant_id=g, set pointer=(g+1) mod NUM_REQ, go to LAUNCH.
  - A requester sees the accept as req_valid[g]&req_ready[g]; it may change its data the next cycle.
- LAUNCH: tx_start=1 for exactly this one cycle. Clear the tick counter, go to FRAME. A baud_tick arriving in this cycle is not counted.
- FRAME:
  - Increment the counter on each baud_tick.
  - On the tick that brings the count to FRAME_TICKS: go to GAP if GAP_TICKS>0, else IDLE. The counter clears.
- GAP:
  - Count baud_tick.
  - On the tick that brings the count to GAP_TICKS: go to IDLE.
- busy=1 in LAUNCH, FRAME and GAP; busy=0 in IDLE.
- req_ready is all-zero outside IDLE. Requests that assert while busy are held off; no data is lost because the producer keeps valid asserted.
- Latency: accept cycle T, then tx_start at T+1, then FRAME from T+2.
  - Earliest next accept is the cycle after the FRAME_TICKS-th counted tick (plus GAP_TICKS ticks when nonzero).
- Simultaneous valids: exactly one is granted per frame, in round-robin order.
  - A requester that keeps valid high waits at most NUM_REQ-1 frames.
- Pointer wrap: a grant to NUM_REQ-1 sets the pointer to 0.
- baud_tick asserted for several consecutive clks counts once per clk in which it is high.
- tx_data holds its value after the frame ends until the next accept.
- req_valid deasserting in IDLE with no accept is legal. It has no effect.

Test Plan:
- Reset and single byte:
  - Stimulus: hold reset=0 for 3 clks, release; set req_valid=4'b0001, req_data[7:0]=8'hA5.
  - Required: req_ready=4'b0001 in that cycle; tx_start for 1 clk the next cycle; tx_data=8'hA5; busy high until the 10th baud_tick after LAUNCH, then IDLE.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held continuously, bytes 8'h10/8'h11/8'h12/8'h13.
  - Required: grant order 0,1,2,3,0; tx_data sequence 10,11,12,13,10; no tx_start while busy.
- Wrap and skip:
  - Stimulus: pointer at 3 after a grant to 2; req_valid=4'b0101.
  - Required: grant 0, then grant 2; req_ready never asserts for requesters 1 or 3.
- Gap:
  - Stimulus: GAP_TICKS=2, two requesters valid.
  - Required: second req_ready asserts only after 12 counted baud_ticks following the first LAUNCH; a baud_tick in the LAUNCH cycle is not counted.
- Reset mid-frame:
  - Stimulus: reset=0 after the 5th tick of a frame.
  - Required: all outputs at reset values on the next clk; after release with valid pending, a grant goes to requester 0 first.
- Back-to-back ticks:
  - Stimulus: baud_tick held high for 10 consecutive clks during FRAME.
  - Required: the frame ends after exactly 10 clks; busy drops on the following clk.
